// File: rtl/ms_stopwatch_pkg.sv
// Shared definitions for the Runner stopwatch: FSM encodings, digit width and defaults.
package ms_stopwatch_pkg;

  // FSM encodings (kept as plain localparams for compatibility with legacy consumers)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned DIGIT_W = 4;

  // Default ticks per centisecond increment
  localparam int unsigned MS_PER_CS_DEFAULT = 10;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // Two-digit BCD encoding of a value 0..99
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/ms_stopwatch_bcd_digit.sv
// Single mod-N BCD digit with ripple carry, synchronous clear and async reset.
module ms_stopwatch_bcd_digit
  import ms_stopwatch_pkg::*;
#(
  parameter int unsigned MODULO = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc_in,
  output bcd_t digit,
  output logic carry_out
);

  localparam bcd_t LAST = bcd_t'(MODULO - 1);

  logic at_max;

  assign at_max    = (digit == LAST);
  assign carry_out = inc_in && at_max;

  // Digit register: clear wins over increment, wraps to 0 after LAST
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (inc_in) begin
      digit <= at_max ? '0 : digit + bcd_t'(1);
    end
  end

endmodule

// File: rtl/ms_stopwatch.sv
// BCD mm:ss.cc game timer driven by the 1 ms tick enable, with start/pause/clear
// control and saturation at MIN_MAX:59.99.
module ms_stopwatch
  import ms_stopwatch_pkg::*;
#(
  parameter int unsigned MS_PER_CS = MS_PER_CS_DEFAULT,
  parameter int unsigned MIN_MAX   = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1ms,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd,
  output logic       running,
  output logic       done,
  output logic       cs_tick
);

  localparam logic [7:0]         MIN_MAX_BCD = to_bcd8(MIN_MAX);
  localparam logic [DIGIT_W-1:0] MS_LAST     = DIGIT_W'(MS_PER_CS - 1);

  logic [1:0]         state, state_d;
  logic [DIGIT_W-1:0] ms_cnt, ms_cnt_d;
  logic               count_en, ms_wrap, at_sat, cs_step, sat_hit;

  bcd_t cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic cs_ones_carry, cs_tens_carry, sec_ones_carry, sec_tens_carry, min_ones_carry;
  logic min_carry_unused;

  assign count_en = (state == ST_RUN) && tick_1ms && !clear;
  assign ms_wrap  = (ms_cnt == MS_LAST);
  assign at_sat   = (min_bcd == MIN_MAX_BCD) && (sec_bcd == 8'h59) && (cs_bcd == 8'h99);
  // The digit chain only advances when not already saturated, so it never wraps
  assign cs_step  = count_en && ms_wrap && !at_sat;
  assign sat_hit  = count_en && ms_wrap && at_sat;

  // Next-state logic: clear > start > pause; saturation overrides a same-cycle pause
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (sat_hit) begin
            state_d = ST_DONE;
          end else if (pause && !start) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (start) state_d = ST_RUN;
        default:  state_d = ST_DONE;
      endcase
    end
  end

  // Sub-centisecond tick counter; retained through PAUSE so resume keeps phase
  always_comb begin
    ms_cnt_d = ms_cnt;
    if (clear) begin
      ms_cnt_d = '0;
    end else if (count_en) begin
      ms_cnt_d = ms_wrap ? '0 : ms_cnt + DIGIT_W'(1);
    end
  end

  // State, tick counter and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ms_cnt  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      cs_tick <= 1'b0;
    end else begin
      state   <= state_d;
      ms_cnt  <= ms_cnt_d;
      running <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
      cs_tick <= cs_step;
    end
  end

  ms_stopwatch_bcd_digit #(.MODULO(10)) u_cs_ones (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(cs_step), .digit(cs_ones), .carry_out(cs_ones_carry)
  );

  ms_stopwatch_bcd_digit #(.MODULO(10)) u_cs_tens (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(cs_ones_carry), .digit(cs_tens), .carry_out(cs_tens_carry)
  );

  ms_stopwatch_bcd_digit #(.MODULO(10)) u_sec_ones (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(cs_tens_carry), .digit(sec_ones), .carry_out(sec_ones_carry)
  );

  ms_stopwatch_bcd_digit #(.MODULO(6)) u_sec_tens (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(sec_ones_carry), .digit(sec_tens), .carry_out(sec_tens_carry)
  );

  ms_stopwatch_bcd_digit #(.MODULO(10)) u_min_ones (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(sec_tens_carry), .digit(min_ones), .carry_out(min_ones_carry)
  );

  // Minute tens carry can never fire: saturation stops the chain first
  ms_stopwatch_bcd_digit #(.MODULO(10)) u_min_tens (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .inc_in(min_ones_carry), .digit(min_tens), .carry_out(min_carry_unused)
  );

  assign cs_bcd  = {cs_tens, cs_ones};
  assign sec_bcd = {sec_tens, sec_ones};
  assign min_bcd = {min_tens, min_ones};

endmodule

// File: tb/tb_ms_stopwatch.sv
// Self-checking bench for ms_stopwatch: two instances (default and MS_PER_CS=1/MIN_MAX=1),
// a behavioural model feeding a scoreboard queue every cycle, a segment table and
// hand-written corner-case sequences.
module tb_ms_stopwatch;

  logic clk = 1'b0;
  logic reset_n;

  logic       t0, s0, p0, c0, t1, s1, p1, c1;
  logic [7:0] min0, sec0, cs0, min1, sec1, cs1;
  logic       run0, done0, cst0, run1, done1, cst1;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt;
  string cur;

  always #5 clk = ~clk;

  ms_stopwatch u_dut0 (
    .clk(clk), .reset_n(reset_n), .tick_1ms(t0), .start(s0), .pause(p0), .clear(c0),
    .min_bcd(min0), .sec_bcd(sec0), .cs_bcd(cs0), .running(run0), .done(done0), .cs_tick(cst0)
  );

  ms_stopwatch #(.MS_PER_CS(1), .MIN_MAX(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tick_1ms(t1), .start(s1), .pause(p1), .clear(c1),
    .min_bcd(min1), .sec_bcd(sec1), .cs_bcd(cs1), .running(run1), .done(done1), .cs_tick(cst1)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] mn, sc, cs;
    logic       run, dn, ct;
  } exp_t;

  exp_t sbq[$];

  int m_st[2], m_ms[2], m_tot[2];
  bit m_cst[2];
  int mpc[2]  = '{10, 1};
  int mmax[2] = '{99, 1};

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset(input int k);
    m_st[k] = 0; m_ms[k] = 0; m_tot[k] = 0; m_cst[k] = 1'b0;
  endtask

  // State codes: 0 idle, 1 run, 2 pause, 3 done; total kept in centiseconds
  task automatic model_step(input int k, input bit t, input bit s, input bit p, input bit c);
    int max_tot;
    max_tot = (mmax[k] * 60 + 59) * 100 + 99;
    m_cst[k] = 1'b0;
    if (c) begin
      m_st[k] = 0; m_ms[k] = 0; m_tot[k] = 0;
    end else if (m_st[k] == 0 || m_st[k] == 2) begin
      if (s) m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (t) begin
        if (m_ms[k] < mpc[k] - 1) begin
          m_ms[k]++;
        end else begin
          m_ms[k] = 0;
          if (m_tot[k] == max_tot) begin
            m_st[k] = 3;
          end else begin
            m_tot[k]++;
            m_cst[k] = 1'b1;
          end
        end
      end
      if (m_st[k] == 1 && p && !s) m_st[k] = 2;
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.mn  = bcd2(m_tot[k] / 6000);
    e.sc  = bcd2((m_tot[k] / 100) % 60);
    e.cs  = bcd2(m_tot[k] % 100);
    e.run = (m_st[k] == 1);
    e.dn  = (m_st[k] == 3);
    e.ct  = m_cst[k];
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_dut(input int k, input exp_t e);
    logic [7:0] mn, sc, cs;
    logic run, dn, ct;
    if (k == 0) begin
      mn = min0; sc = sec0; cs = cs0; run = run0; dn = done0; ct = cst0;
    end else begin
      mn = min1; sc = sec1; cs = cs1; run = run1; dn = done1; ct = cst1;
    end
    n_tests++;
    if (mn !== e.mn || sc !== e.sc || cs !== e.cs || run !== e.run || dn !== e.dn ||
        ct !== e.ct) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h:%h.%h run=%b done=%b cs_tick=%b, required %h:%h.%h run=%b done=%b cs_tick=%b",
               cur, k, mn, sc, cs, run, dn, ct, e.mn, e.sc, e.cs, e.run, e.dn, e.ct);
    end
  endtask

  task automatic expect8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One clock: drive the selected instance, advance both models, queue and compare
  task automatic cycle(input int sel, input bit t, input bit s, input bit p, input bit c);
    bit a;
    exp_t e;
    a = (sel == 0);
    {t0, s0, p0, c0} = a ? {t, s, p, c} : 4'b0;
    {t1, s1, p1, c1} = a ? 4'b0 : {t, s, p, c};
    model_step(0, a & t, a & s, a & p, a & c);
    model_step(1, !a & t, !a & s, !a & p, !a & c);
    sbq.push_back(model_out(0));
    sbq.push_back(model_out(1));
    @(posedge clk);
    #1;
    {t0, s0, p0, c0, t1, s1, p1, c1} = 8'b0;
    e = sbq.pop_front();
    check_dut(0, e);
    if (cst0 === 1'b1) pulse_cnt++;
    e = sbq.pop_front();
    check_dut(1, e);
  endtask

  task automatic ticks(input int sel, input int n);
    for (int i = 0; i < n; i++) cycle(sel, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- segment table for instance 0 ----------------
  typedef struct {
    bit         tick, start, pause, clear;
    int         n_ticks, gap;
    logic [7:0] e_min, e_sec, e_cs;
    logic       e_run;
    int         e_pulses;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset_n = 1'b0;
    {t0, s0, p0, c0, t1, s1, p1, c1} = 8'b0;
    model_reset(0);
    model_reset(1);

    // control cycle bits, n ticks spaced by gap clocks, then expected outputs and cs_tick pulses
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 10,   4, 8'h00, 8'h00, 8'h01, 1'b1, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,    1, 8'h00, 8'h00, 8'h00, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4,    4, 8'h00, 8'h00, 8'h00, 1'b1, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 20,   4, 8'h00, 8'h00, 8'h00, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 5,    4, 8'h00, 8'h00, 8'h01, 1'b1, 1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 0,    1, 8'h00, 8'h00, 8'h00, 1'b0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 3270, 1, 8'h00, 8'h03, 8'h27, 1'b1, 327};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 0,    1, 8'h00, 8'h00, 8'h00, 1'b0, 0};

    // Reset state
    #12;
    cur = "reset";
    check_dut(0, model_out(0));
    check_dut(1, model_out(1));
    #5 reset_n = 1'b1;

    // Ticks before any start are ignored
    cur = "idle_ticks";
    for (int i = 0; i < 12; i++) cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Table-driven segments
    for (int v = 0; v < 8; v++) begin
      $sformat(cur, "seg%0d", v);
      pulse_cnt = 0;
      cycle(0, vecs[v].tick, vecs[v].start, vecs[v].pause, vecs[v].clear);
      for (int i = 0; i < vecs[v].n_ticks; i++) begin
        cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (vecs[v].gap - 1) cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      expect8({cur, "_min"}, min0, vecs[v].e_min);
      expect8({cur, "_sec"}, sec0, vecs[v].e_sec);
      expect8({cur, "_cs"}, cs0, vecs[v].e_cs);
      expect8({cur, "_running"}, {7'b0, run0}, {7'b0, vecs[v].e_run});
      expect_int({cur, "_pulses"}, pulse_cnt, vecs[v].e_pulses);
    end

    // Async reset mid-count: outputs drop with no clock edge
    cur = "async_reset";
    cycle(0, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(0, 25);
    expect8("pre_reset_cs", cs0, 8'h02);
    #2 reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    expect8("async_cs", cs0, 8'h00);
    expect8("async_running", {7'b0, run0}, 8'h00);
    check_dut(0, model_out(0));
    #2 reset_n = 1'b1;
    cur = "post_reset_ticks";
    ticks(0, 15);
    expect8("post_reset_cs", cs0, 8'h00);

    // Instance 1: one tick per centisecond, saturates at 01:59.99
    cur = "fast";
    cycle(1, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1, 99);
    expect8("fast_cs99", cs1, 8'h99);
    expect8("fast_sec00", sec1, 8'h00);
    ticks(1, 1);
    expect8("fast_cs_carry", cs1, 8'h00);
    expect8("fast_sec01", sec1, 8'h01);
    ticks(1, 5899);
    expect8("fast_sec59", sec1, 8'h59);
    expect8("fast_cs99b", cs1, 8'h99);
    ticks(1, 1);
    expect8("fast_min01", min1, 8'h01);
    expect8("fast_sec_carry", sec1, 8'h00);
    expect8("fast_cs00", cs1, 8'h00);
    ticks(1, 5999);
    expect8("pre_sat_min", min1, 8'h01);
    expect8("pre_sat_running", {7'b0, run1}, 8'h01);
    cur = "saturate";
    ticks(1, 10);
    expect8("sat_min", min1, 8'h01);
    expect8("sat_sec", sec1, 8'h59);
    expect8("sat_cs", cs1, 8'h99);
    expect8("sat_done", {7'b0, done1}, 8'h01);
    expect8("sat_running", {7'b0, run1}, 8'h00);
    cur = "done_ignores";
    cycle(1, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1, 5);
    cycle(1, 1'b1, 1'b0, 1'b1, 1'b0);
    expect8("done_hold_cs", cs1, 8'h99);
    expect8("done_hold_done", {7'b0, done1}, 8'h01);
    cur = "done_clear";
    cycle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect8("clear_min", min1, 8'h00);
    expect8("clear_cs", cs1, 8'h00);
    expect8("clear_done", {7'b0, done1}, 8'h00);
    ticks(1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
